// File: rtl/beam_pulse_sequencer.sv
// Multi-channel transmit gate sequencer: per-channel on/off ticks inside a repeating frame, double-buffered at frame wrap.
// Optional feature macro BEAM_BIPOLAR_EN: negOutput drives a mirrored pulse right after each positive window.
module beam_pulse_sequencer #(
    parameter  int unsigned NUM_CH   = 8,
    parameter  int unsigned CNT_W    = 12,
    parameter  int unsigned TICK_DIV = 125,
    parameter  int unsigned PERIOD   = 2000,
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_on,
    input  logic [CNT_W-1:0]  cfg_off,
    input  logic              start,
    input  logic              stop,
    output logic              busy,
    output logic              frame_done,
    output logic [NUM_CH-1:0] posOutput,
    output logic [NUM_CH-1:0] negOutput
);

    localparam int unsigned     PS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    state_t            state_next;
    logic [PS_W-1:0]   presc;
    logic [PS_W-1:0]   presc_next;
    logic [CNT_W-1:0]  counter;
    logic [CNT_W-1:0]  counter_next;
    logic              stop_pend;
    logic              stop_pend_next;
    logic              tick;
    logic              wrap;
    logic              load_active;
    logic              out_en;

    logic [CNT_W-1:0]  shadow_on  [NUM_CH];
    logic [CNT_W-1:0]  shadow_off [NUM_CH];
    logic [CNT_W-1:0]  active_on  [NUM_CH];
    logic [CNT_W-1:0]  active_off [NUM_CH];
    logic [NUM_CH-1:0] pos_win;
    logic [NUM_CH-1:0] neg_win;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, tick prescaler, frame counter and pending stop
    always_comb begin
        state_next     = state;
        presc_next     = '0;
        counter_next   = '0;
        stop_pend_next = 1'b0;
        tick           = 1'b0;
        wrap           = 1'b0;
        load_active    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next  = RUN;
                    load_active = 1'b1;
                end
            end
            RUN: begin
                tick           = (presc == PS_LAST);
                wrap           = tick && (counter == CNT_LAST);
                presc_next     = tick ? '0 : presc + PS_W'(1);
                stop_pend_next = stop_pend | stop;
                if (!tick) begin
                    counter_next = counter;
                end else if (!wrap) begin
                    counter_next = counter + CNT_W'(1);
                end
                // A stop arriving on the wrap clock still ends this frame
                if (wrap) begin
                    load_active    = 1'b1;
                    stop_pend_next = 1'b0;
                    if (stop_pend | stop) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are gated off on the same edge the sequencer leaves RUN
    assign out_en = (state == RUN) && (state_next == RUN);

    // Per-channel gate windows against the active delay set
    always_comb begin : win_calc
`ifdef BEAM_BIPOLAR_EN
        logic [CNT_W:0] neg_end;
        neg_end = '0;
`endif
        pos_win = '0;
        neg_win = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pos_win[i] = (counter >= active_on[i]) && (counter < active_off[i]);
`ifdef BEAM_BIPOLAR_EN
            // End may exceed PERIOD; the counter never gets there, so the pulse clips at frame end
            neg_end    = {1'b0, active_off[i]} + ({1'b0, active_off[i]} - {1'b0, active_on[i]});
            neg_win[i] = (active_on[i] < active_off[i]) && (counter >= active_off[i])
                         && ({1'b0, counter} < neg_end);
`endif
        end
    end

    // Datapath, shadow/active delay registers and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc      <= '0;
            counter    <= '0;
            stop_pend  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            posOutput  <= '0;
            negOutput  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_on[i]  <= '0;
                shadow_off[i] <= '0;
                active_on[i]  <= '0;
                active_off[i] <= '0;
            end
        end else begin
            presc      <= presc_next;
            counter    <= counter_next;
            stop_pend  <= stop_pend_next;
            busy       <= (state_next == RUN);
            frame_done <= (state_next == RUN) && (presc_next == PS_LAST) && (counter_next == CNT_LAST);
            posOutput  <= out_en ? pos_win : '0;
            negOutput  <= out_en ? neg_win : '0;
            // Copy reads pre-write shadow, so a same-clock write lands in the next frame
            for (int i = 0; i < NUM_CH; i++) begin
                if (load_active) begin
                    active_on[i]  <= shadow_on[i];
                    active_off[i] <= shadow_off[i];
                end
                if (cfg_we && (cfg_ch == CH_W'(i))) begin
                    shadow_on[i]  <= cfg_on;
                    shadow_off[i] <= cfg_off;
                end
            end
        end
    end

endmodule

// File: tb/tb_beam_pulse_sequencer.sv
// Directed bench for beam_pulse_sequencer (NUM_CH=6, CNT_W=5, TICK_DIV=2, PERIOD=20); honours BEAM_BIPOLAR_EN.
module tb_beam_pulse_sequencer;

    localparam int unsigned NUM_CH   = 6;
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned TICK_DIV = 2;
    localparam int unsigned PERIOD   = 20;
`ifdef BEAM_BIPOLAR_EN
    localparam bit BIP = 1'b1;
`else
    localparam bit BIP = 1'b0;
`endif

    logic              clock;
    logic              reset;
    logic              cfg_we;
    logic [2:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_on;
    logic [CNT_W-1:0]  cfg_off;
    logic              start;
    logic              stop;
    logic              busy;
    logic              frame_done;
    logic [NUM_CH-1:0] posOutput;
    logic [NUM_CH-1:0] negOutput;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    beam_pulse_sequencer #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .TICK_DIV(TICK_DIV),
        .PERIOD  (PERIOD)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_on    (cfg_on),
        .cfg_off   (cfg_off),
        .start     (start),
        .stop      (stop),
        .busy      (busy),
        .frame_done(frame_done),
        .posOutput (posOutput),
        .negOutput (negOutput)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic w(input int lo, input int hi, input int tt);
        return (tt >= lo) && (tt < hi);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs set at the previous negedge are sampled, strobes then drop
    task automatic step();
        @(posedge clock);
        cyc++;
        @(negedge clock);
        start  = 1'b0;
        stop   = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic drive_cfg(input int ch, input int on, input int off);
        cfg_we  = 1'b1;
        cfg_ch  = 3'(ch);
        cfg_on  = CNT_W'(on);
        cfg_off = CNT_W'(off);
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        cyc = 0;
    endtask

    task automatic chk_idle(input string tag);
        chk($sformatf("%s_busy", tag), 32'(busy), 32'd0);
        chk($sformatf("%s_fd", tag), 32'(frame_done), 32'd0);
        chk($sformatf("%s_pos", tag), 32'(posOutput), 32'd0);
        chk($sformatf("%s_neg", tag), 32'(negOutput), 32'd0);
    endtask

    // Running-cycle check; neg expectation applies only in the bipolar build
    task automatic chk_cycle(input string tag, input logic [5:0] ep, input logic [5:0] en);
        chk($sformatf("%s_pos_c%0d", tag, cyc), 32'(posOutput), 32'(ep));
        chk($sformatf("%s_neg_c%0d", tag, cyc), 32'(negOutput), BIP ? 32'(en) : 32'd0);
        chk($sformatf("%s_busy_c%0d", tag, cyc), 32'(busy), 32'd1);
        chk($sformatf("%s_fd_c%0d", tag, cyc), 32'(frame_done), 32'((cyc % 40) == 39));
    endtask

    initial begin
        int   t;
        logic p0, n0, p1, n1;

        reset   = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        cfg_we  = 1'b0;
        cfg_ch  = '0;
        cfg_on  = '0;
        cfg_off = '0;
        repeat (3) @(negedge clock);
        chk_idle("reset");
        reset = 1'b0;
        @(negedge clock);

        // Test 1/2: ch0 0..9, ch3 5..7; mid-frame ch0 rewrite lands one frame later
        drive_cfg(0, 0, 10); step();
        drive_cfg(3, 5, 8);  step();
        step();
        chk_idle("idle_cfg");
        do_start();
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_pos", 32'(posOutput), 32'd0);
        for (int n = 1; n <= 120; n++) begin
            step();
            t  = ((cyc - 1) % 40) / 2;
            p0 = (cyc <= 80) ? w(0, 10, t) : w(2, 4, t);
            n0 = (cyc <= 80) ? w(10, 20, t) : w(4, 6, t);
            chk_cycle("t12", {2'b0, w(5, 8, t), 2'b0, p0}, {2'b0, w(8, 11, t), 2'b0, n0});
            if (cyc == 50) drive_cfg(0, 2, 4);
        end

        // Test 3: stop at tick 7 of frame 3, frame still runs to its end
        for (int n = 121; n <= 159; n++) begin
            step();
            t = ((cyc - 1) % 40) / 2;
            chk_cycle("t3", {2'b0, w(5, 8, t), 2'b0, w(2, 4, t)}, {2'b0, w(8, 11, t), 2'b0, w(4, 6, t)});
            if (cyc == 134) stop = 1'b1;
        end
        step();
        chk_idle("stop_end");
        stop = 1'b1;
        step();
        chk_idle("stop_idle");
        drive_cfg(0, 0, 10);
        step();
        chk_idle("cfg_in_idle");

        // Restart from tick 0; a start while running must not disturb the frame
        do_start();
        chk("restart_busy", 32'(busy), 32'd1);
        for (int n = 1; n <= 13; n++) begin
            step();
            t = ((cyc - 1) % 40) / 2;
            chk_cycle("restart", {2'b0, w(5, 8, t), 2'b0, w(0, 10, t)}, {2'b0, w(8, 11, t), 2'b0, w(10, 20, t)});
            if (cyc == 5) start = 1'b1;
        end

        // Test 4: asynchronous reset at tick 6 with pos[0] high
        chk("pre_reset_pos0", 32'(posOutput[0]), 32'd1);
        #2 reset = 1'b1;
        #1 chk_idle("async_reset");
        @(negedge clock);
        reset = 1'b0;
        step();
        step();
        chk_idle("post_reset");

        // Test 5/6: degenerate windows, out-of-range channel writes, bipolar pulses
        drive_cfg(0, 0, 10);  step();
        drive_cfg(1, 4, 7);   step();
        drive_cfg(2, 12, 12); step();
        drive_cfg(6, 0, 20);  step();
        drive_cfg(7, 0, 20);  step();
        chk_idle("t5_idle");
        do_start();
        for (int n = 1; n <= 80; n++) begin
            step();
            t  = ((cyc - 1) % 40) / 2;
            p1 = (cyc <= 40) ? w(4, 7, t) : w(10, 16, t);
            n1 = (cyc <= 40) ? w(7, 10, t) : w(16, 20, t);
            chk_cycle("t56", {4'b0, p1, w(0, 10, t)}, {4'b0, n1, w(10, 20, t)});
            if (cyc == 30) drive_cfg(1, 10, 16);
            if (cyc == 31) drive_cfg(2, 15, 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
